// File: rtl/onewire_responder.sv
// onewire_responder: single-wire half-duplex responder; receives a request byte, then drives a held response byte.
// Define ONEWIRE_RESPONDER_PARITY_EN to add an even-parity bit after data bit 7 in both directions.
module onewire_responder #(
  parameter int BIT_CYCLES  = 16,
  parameter int TURN_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pad_i,
  output logic       pad_o,
  output logic       pad_t,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] rsp_data,
  input  logic       rsp_valid,
  output logic       rsp_ready,
  output logic       frame_err,
  output logic       busy
);
`ifdef ONEWIRE_RESPONDER_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif
  typedef enum logic [2:0] {IDLE, RX_START, RX_DATA, RX_STOP, TURN, TX_START, TX_DATA, TX_STOP} state_t;
  state_t          state;
  logic            s1, s2, s3;
  logic [15:0]     cnt;
  logic [3:0]      idx;
  logic [NB-1:0]   rx_sh, tx_sh, tx_load;
  logic [7:0]      rsp_reg;
  logic            rsp_full;
  logic            bit_end, half, is_tx, frame_ok;
  assign bit_end   = cnt == 16'(BIT_CYCLES - 1);
  assign half      = cnt == 16'(BIT_CYCLES / 2 - 1);
  assign is_tx     = state inside {TX_START, TX_DATA, TX_STOP};
  assign busy      = state != IDLE;
  assign rsp_ready = !rsp_full;
`ifdef ONEWIRE_RESPONDER_PARITY_EN
  assign frame_ok  = s2 && (rx_sh[8] == ^rx_sh[7:0]);
  assign tx_load   = {^rsp_reg, rsp_reg};
`else
  assign frame_ok  = s2;
  assign tx_load   = rsp_reg;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      s1        <= 1'b1;
      s2        <= 1'b1;
      s3        <= 1'b1;
      cnt       <= '0;
      idx       <= '0;
      rx_sh     <= '0;
      tx_sh     <= '0;
      rsp_reg   <= '0;
      rsp_full  <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      pad_t     <= 1'b1;
      pad_o     <= 1'b1;
    end else begin
      s1        <= pad_i;
      s2        <= s1;
      s3        <= s2;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      cnt       <= cnt + 16'd1;
      if (rsp_valid && !rsp_full && !is_tx) begin
        rsp_full <= 1'b1;
        rsp_reg  <= rsp_data;
      end
      case (state)
        IDLE: begin
          cnt <= '0;
          if (s3 && !s2) state <= RX_START;
        end
        RX_START: if (half) begin
          cnt   <= '0;
          idx   <= '0;
          state <= s2 ? IDLE : RX_DATA;
        end
        RX_DATA: if (bit_end) begin
          cnt   <= '0;
          rx_sh <= {s2, rx_sh[NB-1:1]};
          idx   <= idx + 4'd1;
          if (idx == 4'(NB - 1)) state <= RX_STOP;
        end
        RX_STOP: if (bit_end) begin
          cnt <= '0;
          if (frame_ok) begin
            rx_data  <= rx_sh[7:0];
            rx_valid <= 1'b1;
            state    <= TURN;
          end else begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end
        end
        TURN: if (cnt == 16'(TURN_CYCLES - 1)) begin
          cnt <= '0;
          if (rsp_full) begin
            state    <= TX_START;
            pad_t    <= 1'b0;
            pad_o    <= 1'b0;
            rsp_full <= 1'b0;
            tx_sh    <= tx_load;
          end else state <= IDLE;
        end
        TX_START: if (bit_end) begin
          cnt   <= '0;
          idx   <= '0;
          state <= TX_DATA;
          pad_o <= tx_sh[0];
          tx_sh <= tx_sh >> 1;
        end
        TX_DATA: if (bit_end) begin
          cnt <= '0;
          idx <= idx + 4'd1;
          if (idx == 4'(NB - 1)) begin
            state <= TX_STOP;
            pad_o <= 1'b1;
          end else begin
            pad_o <= tx_sh[0];
            tx_sh <= tx_sh >> 1;
          end
        end
        TX_STOP: if (bit_end) begin
          cnt   <= '0;
          state <= IDLE;
          pad_t <= 1'b1;
          pad_o <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_onewire_responder.sv
// tb_onewire_responder: randomized request/response frames checked against a bit-level frame model.
module tb_onewire_responder;
  localparam int BIT = 16;
  localparam int TRN = 32;
`ifdef ONEWIRE_RESPONDER_PARITY_EN
  localparam int NBF = 11;
`else
  localparam int NBF = 10;
`endif
  logic clk = 0, rst_n = 0, host = 1, rsp_valid = 0;
  logic [7:0] rsp_data = 0;
  logic pad_i, pad_o, pad_t, rx_valid, rsp_ready, frame_err, busy;
  logic [7:0] rx_data;
  int checks = 0, passes = 0, cyc = 0;
  int rxv_n = 0, fe_n = 0, t_valid = 0, t_fall = 0;
  logic [7:0] rx_last = 0;
  logic pt_prev = 1;
  assign pad_i = pad_t ? host : pad_o;
  onewire_responder #(.BIT_CYCLES(BIT), .TURN_CYCLES(TRN)) dut (
    .clk(clk), .rst_n(rst_n), .pad_i(pad_i), .pad_o(pad_o), .pad_t(pad_t),
    .rx_data(rx_data), .rx_valid(rx_valid), .rsp_data(rsp_data), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .frame_err(frame_err), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rx_valid) begin
      rxv_n   <= rxv_n + 1;
      rx_last <= rx_data;
      t_valid <= cyc;
    end
    if (frame_err) fe_n <= fe_n + 1;
    if (pt_prev && !pad_t) t_fall <= cyc;
    pt_prev <= pad_t;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  // Line frame, LSB first: start, 8 data, [even parity], stop.
  function automatic logic [10:0] frame_of(input logic [7:0] d, input logic bad_par, input logic stop);
    logic [10:0] f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = d[i];
    f[9] = (($countones(d) % 2) != 0) ^ bad_par;
    f[NBF-1] = stop;
    return f;
  endfunction
  task automatic send_bits(input logic [10:0] f);
    @(negedge clk);
    for (int i = 0; i < NBF; i++) begin
      host = f[i];
      repeat (BIT) @(negedge clk);
    end
    host = 1'b1;
  endtask
  task automatic offer(input logic [7:0] d);
    @(negedge clk);
    rsp_data = d;
    rsp_valid = 1'b1;
    @(negedge clk);
    rsp_valid = 1'b0;
  endtask
  task automatic capture_tx(output logic [10:0] got, output logic seen, output logic held, output logic rel);
    int w = 0;
    got = '1;
    held = 1'b1;
    while (pad_t === 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    seen = pad_t === 1'b0;
    rel = 1'b0;
    if (seen) begin
      for (int i = 0; i < NBF; i++) begin
        repeat (i == 0 ? 8 : 16) @(negedge clk);
        got[i] = pad_o;
        if (pad_t !== 1'b0) held = 1'b0;
      end
      repeat (7) @(negedge clk);
      if (pad_t !== 1'b0) held = 1'b0;
      @(negedge clk);
      rel = pad_t === 1'b1 && pad_o === 1'b1;
    end
  endtask
  task automatic test_reset;
    rst_n = 0;
    repeat (3) @(negedge clk);
    checks++; if ({pad_t, pad_o, rx_valid, frame_err, busy, rsp_ready} !== 6'b110001) $display("FAIL reset_outs: got %b exp 110001", {pad_t, pad_o, rx_valid, frame_err, busy, rsp_ready}); else passes++;
    checks++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h exp 00", rx_data); else passes++;
    rst_n = 1;
    repeat (3) @(negedge clk);
  endtask
  task automatic test_request_response;
    logic [10:0] got, exp;
    logic seen, held, rel;
    logic [7:0] req, rsp;
    int n0;
    for (int k = 0; k < 4; k++) begin
      req = (k == 0) ? 8'hA5 : 8'($urandom);
      rsp = (k == 0) ? 8'h3C : 8'($urandom);
      offer(rsp);
      checks++; if (rsp_ready !== 1'b0) $display("FAIL rr_preload_ready: got %b exp 0", rsp_ready); else passes++;
      n0 = rxv_n;
      send_bits(frame_of(req, 1'b0, 1'b1));
      checks++; if (rxv_n - n0 !== 1 || rx_last !== req) $display("FAIL rr_rx: pulses %0d data %h exp 1 pulse data %h", rxv_n - n0, rx_last, req); else passes++;
      capture_tx(got, seen, held, rel);
      exp = frame_of(rsp, 1'b0, 1'b1);
      checks++; if (!seen || got[NBF-1:0] !== exp[NBF-1:0]) $display("FAIL rr_tx_bits: got %b exp %b seen %b", got[NBF-1:0], exp[NBF-1:0], seen); else passes++;
      checks++; if (t_fall - t_valid !== TRN) $display("FAIL rr_turn: got %0d exp %0d", t_fall - t_valid, TRN); else passes++;
      checks++; if (!held || !rel) $display("FAIL rr_release: held %b released %b exp 1 1", held, rel); else passes++;
      checks++; if (busy !== 1'b0 || rsp_ready !== 1'b1) $display("FAIL rr_idle: busy %b ready %b exp 0 1", busy, rsp_ready); else passes++;
      repeat (5) @(negedge clk);
    end
  endtask
  task automatic test_no_response;
    logic [7:0] req;
    int n0, lows = 0;
    for (int k = 0; k < 2; k++) begin
      req = (k == 0) ? 8'h5A : 8'($urandom);
      n0 = rxv_n;
      send_bits(frame_of(req, 1'b0, 1'b1));
      checks++; if (rxv_n - n0 !== 1 || rx_last !== req) $display("FAIL norsp_rx: pulses %0d data %h exp 1 pulse data %h", rxv_n - n0, rx_last, req); else passes++;
      lows = 0;
      repeat (60) begin
        @(negedge clk);
        if (pad_t !== 1'b1) lows++;
      end
      checks++; if (lows !== 0 || busy !== 1'b0) $display("FAIL norsp_idle: driven cycles %0d busy %b exp 0 0", lows, busy); else passes++;
    end
  endtask
  task automatic test_glitch;
    int n0 = rxv_n, f0 = fe_n;
    @(negedge clk);
    host = 1'b0;
    repeat (4) @(negedge clk);
    host = 1'b1;
    repeat (30) @(negedge clk);
    checks++; if (rxv_n !== n0 || fe_n !== f0 || busy !== 1'b0) $display("FAIL glitch: rx %0d fe %0d busy %b exp 0 0 0", rxv_n - n0, fe_n - f0, busy); else passes++;
  endtask
  task automatic test_frame_err;
    logic [7:0] prev = rx_data;
    int n0 = rxv_n, f0 = fe_n, lows = 0;
    offer(8'hC3);
    send_bits(frame_of(8'h11, 1'b0, 1'b0));
    repeat (80) begin
      @(negedge clk);
      if (pad_t !== 1'b1) lows++;
    end
    checks++; if (fe_n - f0 !== 1 || rxv_n !== n0) $display("FAIL ferr_pulses: fe %0d rx %0d exp 1 0", fe_n - f0, rxv_n - n0); else passes++;
    checks++; if (rx_data !== prev || lows !== 0 || rsp_ready !== 1'b0) $display("FAIL ferr_state: rx_data %h driven %0d ready %b exp %h 0 0", rx_data, lows, rsp_ready, prev); else passes++;
  endtask
  task automatic test_held_response;
    logic [10:0] got, exp;
    logic seen, held, rel;
    send_bits(frame_of(8'($urandom), 1'b0, 1'b1));
    capture_tx(got, seen, held, rel);
    exp = frame_of(8'hC3, 1'b0, 1'b1);
    checks++; if (!seen || got[NBF-1:0] !== exp[NBF-1:0]) $display("FAIL held_tx: got %b exp %b", got[NBF-1:0], exp[NBF-1:0]); else passes++;
    repeat (5) @(negedge clk);
  endtask
  task automatic test_reset_mid_tx;
    int w = 0;
    offer(8'($urandom) & 8'hF7);
    send_bits(frame_of(8'($urandom), 1'b0, 1'b1));
    while (pad_t === 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    repeat (4 * BIT + 8) @(negedge clk);
    checks++; if (pad_t !== 1'b0 || pad_o !== 1'b0) $display("FAIL rst_tx_pre: pad_t %b pad_o %b exp 0 0", pad_t, pad_o); else passes++;
    rst_n = 0;
    #1;
    checks++; if (pad_t !== 1'b1 || pad_o !== 1'b1) $display("FAIL rst_tx_async: pad_t %b pad_o %b exp 1 1", pad_t, pad_o); else passes++;
    @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    checks++; if (rsp_ready !== 1'b1 || busy !== 1'b0) $display("FAIL rst_tx_after: ready %b busy %b exp 1 0", rsp_ready, busy); else passes++;
  endtask
`ifdef ONEWIRE_RESPONDER_PARITY_EN
  task automatic test_parity;
    logic [10:0] got, exp;
    logic seen, held, rel;
    int n0 = rxv_n, f0 = fe_n;
    offer(8'($urandom));
    exp = frame_of(dut.rsp_data, 1'b0, 1'b1);
    send_bits(frame_of(8'h07, 1'b1, 1'b1));
    repeat (40) @(negedge clk);
    checks++; if (fe_n - f0 !== 1 || rxv_n !== n0 || rsp_ready !== 1'b0) $display("FAIL par_bad: fe %0d rx %0d ready %b exp 1 0 0", fe_n - f0, rxv_n - n0, rsp_ready); else passes++;
    send_bits(frame_of(8'h07, 1'b0, 1'b1));
    checks++; if (rxv_n - n0 !== 1 || rx_last !== 8'h07) $display("FAIL par_good: pulses %0d data %h exp 1 07", rxv_n - n0, rx_last); else passes++;
    capture_tx(got, seen, held, rel);
    checks++; if (!seen || got[NBF-1:0] !== exp[NBF-1:0]) $display("FAIL par_tx: got %b exp %b", got[NBF-1:0], exp[NBF-1:0]); else passes++;
  endtask
`endif
  initial begin
    test_reset;
    test_request_response;
    test_no_response;
    test_glitch;
    test_frame_err;
    test_held_response;
    test_reset_mid_tx;
`ifdef ONEWIRE_RESPONDER_PARITY_EN
    test_parity;
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
